// File: rtl/duzen_min_counter_pkg.sv
// Shared types and constants for the minutes counter: FSM states, digit limits and widths.
package duzen_min_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2
   } state_t;

   localparam int U_MAX = 9;
   localparam int D_MAX = 5;
   localparam int U_W   = 4;
   localparam int D_W   = 3;

endpackage

// File: rtl/duzen_min_counter_bcd_digit.sv
// One modulo-MOD counter digit with clear > load > increment priority.
// o_wrap flags that the digit sits at its top value; the caller gates it with inc.
module bcd_digit #(
   parameter int MOD = 10,
   parameter int W   = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   input  logic         i_load,
   input  logic [W-1:0] i_ld_val,
   input  logic         i_clr,
   output logic [W-1:0] o_val,
   output logic         o_wrap
);

   localparam logic [W-1:0] LP_TOP = W'(MOD - 1);

   logic [W-1:0] r_val;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_val <= '0;
      end else if (i_clr) begin
         r_val <= '0;
      end else if (i_load) begin
         // Out-of-range presets collapse to zero rather than producing a non-BCD digit
         r_val <= (i_ld_val > LP_TOP) ? '0 : i_ld_val;
      end else if (i_inc) begin
         r_val <= (r_val == LP_TOP) ? '0 : r_val + 1'b1;
      end
   end

   assign o_val  = r_val;
   assign o_wrap = (r_val == LP_TOP);

endmodule

// File: rtl/duzen_min_counter.sv
// Minutes stage (00-59) of a stopwatch: IDLE/RUNNING/PAUSED control with CLR > LOAD > STOP > START.
// All outputs registered; count updates one cycle after the minute pulse.
module duzen_min_counter
   import duzen_min_counter_pkg::*;
(
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_p,
   input  logic           i_start,
   input  logic           i_stop,
   input  logic           i_clr,
   input  logic           i_load,
   input  logic [U_W-1:0] i_ld_u,
   input  logic [D_W-1:0] i_ld_d,
   output logic [U_W-1:0] o_u,
   output logic [D_W-1:0] o_d,
   output logic           o_run,
   output logic           o_cy,
   output logic           o_ovf
);

   state_t r_state;
   state_t w_state_nxt;
   logic   r_run;
   logic   r_cy;
   logic   r_ovf;

   logic w_load_en;
   logic w_inc;
   logic w_u_wrap;
   logic w_d_wrap;
   logic w_wrap;

   assign w_load_en = i_load & ~i_clr;
   // STOP beats a coincident pulse: the pulse is dropped, not deferred
   assign w_inc     = (r_state == ST_RUNNING) & i_p & ~i_clr & ~i_load & ~i_stop;
   assign w_wrap    = w_inc & w_u_wrap & w_d_wrap;

   always_comb begin
      w_state_nxt = r_state;
      if (i_clr) begin
         w_state_nxt = ST_IDLE;
      end else if (i_load) begin
         w_state_nxt = r_state;
      end else if (i_stop) begin
         if (r_state == ST_RUNNING) begin
            w_state_nxt = ST_PAUSED;
         end
      end else if (i_start) begin
         if (r_state == ST_IDLE || r_state == ST_PAUSED) begin
            w_state_nxt = ST_RUNNING;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_run   <= 1'b0;
         r_cy    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= (w_state_nxt == ST_RUNNING);
         r_cy    <= w_wrap;
         r_ovf   <= i_clr ? 1'b0 : (r_ovf | w_wrap);
      end
   end

   bcd_digit #(
      .MOD (U_MAX + 1),
      .W   (U_W)
   ) u_units (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_inc    (w_inc),
      .i_load   (w_load_en),
      .i_ld_val (i_ld_u),
      .i_clr    (i_clr),
      .o_val    (o_u),
      .o_wrap   (w_u_wrap)
   );

   bcd_digit #(
      .MOD (D_MAX + 1),
      .W   (D_W)
   ) u_tens (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_inc    (w_inc & w_u_wrap),
      .i_load   (w_load_en),
      .i_ld_val (i_ld_d),
      .i_clr    (i_clr),
      .o_val    (o_d),
      .o_wrap   (w_d_wrap)
   );

   assign o_run = r_run;
   assign o_cy  = r_cy;
   assign o_ovf = r_ovf;

endmodule

// File: tb/tb_duzen_min_counter.sv
// Directed bench for duzen_min_counter: one task per scenario, hand-computed expectations.
module tb_duzen_min_counter;

   logic       clk;
   logic       rst_n;
   logic       p;
   logic       start;
   logic       stop;
   logic       clr;
   logic       load;
   logic [3:0] ld_u;
   logic [2:0] ld_d;
   logic [3:0] u;
   logic [2:0] d;
   logic       run;
   logic       cy;
   logic       ovf;

   int errors = 0;
   int checks = 0;

   duzen_min_counter dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_p     (p),
      .i_start (start),
      .i_stop  (stop),
      .i_clr   (clr),
      .i_load  (load),
      .i_ld_u  (ld_u),
      .i_ld_d  (ld_d),
      .o_u     (u),
      .o_d     (d),
      .o_run   (run),
      .o_cy    (cy),
      .o_ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      p = 0; start = 0; stop = 0; clr = 0; load = 0; ld_u = 0; ld_d = 0;
   endtask

   task automatic do_clr();
      clr = 1; tick(); clr = 0;
   endtask

   task automatic do_load(input logic [3:0] lu, input logic [2:0] ldd);
      load = 1; ld_u = lu; ld_d = ldd; tick(); load = 0;
   endtask

   task automatic do_start();
      start = 1; tick(); start = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      #12;
      checks++; if ({u, d, run, cy, ovf} !== 10'd0) begin errors++;
         $display("FAIL reset_outputs: got u=%0d d=%0d run=%0b cy=%0b ovf=%0b expected all 0", u, d, run, cy, ovf); end
      @(negedge clk); rst_n = 1;
      p = 1; tick(); p = 0;
      checks++; if ({u, d, run} !== 8'd0) begin errors++;
         $display("FAIL reset_idle_ignores_p: got u=%0d d=%0d run=%0b expected 0 0 0", u, d, run); end
   endtask

   task automatic test_count();
      logic cy_seen;
      cy_seen = 0;
      do_start();
      checks++; if (run !== 1'b1) begin errors++; $display("FAIL count_run: got %0b expected 1", run); end
      for (int i = 0; i < 10; i++) begin
         p = 1; tick(); cy_seen |= cy;
         p = 0; tick(); cy_seen |= cy;
      end
      checks++; if ({d, u} !== {3'd1, 4'd0}) begin errors++;
         $display("FAIL count_10_pulses: got %0d%0d expected 10", d, u); end
      checks++; if (cy_seen !== 1'b0) begin errors++; $display("FAIL count_no_cy: got %0b expected 0", cy_seen); end
      checks++; if (run !== 1'b1) begin errors++; $display("FAIL count_still_run: got %0b expected 1", run); end
   endtask

   task automatic test_wrap();
      do_clr();
      checks++; if ({d, u, run} !== 8'd0) begin errors++;
         $display("FAIL wrap_clr: got d=%0d u=%0d run=%0b expected 0 0 0", d, u, run); end
      do_load(4'd8, 3'd5);
      checks++; if ({d, u} !== {3'd5, 4'd8}) begin errors++; $display("FAIL wrap_load: got %0d%0d expected 58", d, u); end
      do_start();
      p = 1; tick();
      checks++; if ({d, u, cy} !== {3'd5, 4'd9, 1'b0}) begin errors++;
         $display("FAIL wrap_first_pulse: got %0d%0d cy=%0b expected 59 cy=0", d, u, cy); end
      tick(); p = 0;
      checks++; if ({d, u, cy, ovf} !== {3'd0, 4'd0, 1'b1, 1'b1}) begin errors++;
         $display("FAIL wrap_59_to_00: got %0d%0d cy=%0b ovf=%0b expected 00 cy=1 ovf=1", d, u, cy, ovf); end
      tick();
      checks++; if ({cy, ovf} !== 2'b01) begin errors++;
         $display("FAIL wrap_cy_one_cycle: got cy=%0b ovf=%0b expected cy=0 ovf=1", cy, ovf); end
   endtask

   task automatic test_stop_with_p();
      do_clr();
      do_load(4'd2, 3'd1);
      do_start();
      stop = 1; p = 1; tick(); stop = 0; p = 0;
      checks++; if ({d, u, run} !== {3'd1, 4'd2, 1'b0}) begin errors++;
         $display("FAIL stop_beats_p: got %0d%0d run=%0b expected 12 run=0", d, u, run); end
      for (int i = 0; i < 3; i++) begin
         p = 1; tick(); p = 0; tick();
      end
      checks++; if ({d, u, run} !== {3'd1, 4'd2, 1'b0}) begin errors++;
         $display("FAIL paused_ignores_p: got %0d%0d run=%0b expected 12 run=0", d, u, run); end
      do_start();
      checks++; if (run !== 1'b1) begin errors++; $display("FAIL resume_run: got %0b expected 1", run); end
      p = 1; tick(); p = 0;
      checks++; if ({d, u} !== {3'd1, 4'd3}) begin errors++; $display("FAIL resume_count: got %0d%0d expected 13", d, u); end
   endtask

   task automatic test_illegal_load();
      do_clr();
      do_load(4'd12, 3'd7);
      checks++; if ({d, u} !== 7'd0) begin errors++; $display("FAIL load_both_illegal: got %0d%0d expected 00", d, u); end
      do_load(4'd3, 3'd4);
      checks++; if ({d, u} !== {3'd4, 4'd3}) begin errors++; $display("FAIL load_43: got %0d%0d expected 43", d, u); end
      do_load(4'd10, 3'd2);
      checks++; if ({d, u} !== {3'd2, 4'd0}) begin errors++; $display("FAIL load_units_illegal: got %0d%0d expected 20", d, u); end
      do_load(4'd9, 3'd6);
      checks++; if ({d, u} !== {3'd0, 4'd9}) begin errors++; $display("FAIL load_tens_illegal: got %0d%0d expected 09", d, u); end
   endtask

   task automatic test_start_stop_both();
      start = 1; stop = 1; p = 1; tick(); start = 0; stop = 0; p = 0;
      checks++; if ({run, d, u} !== {1'b0, 3'd0, 4'd9}) begin errors++;
         $display("FAIL start_stop_both: got run=%0b %0d%0d expected run=0 09", run, d, u); end
   endtask

   task automatic test_clr_load();
      do_load(4'd9, 3'd5);
      do_start();
      p = 1; tick(); p = 0;
      do_load(4'd7, 3'd2);
      checks++; if ({d, u, ovf, run} !== {3'd2, 4'd7, 1'b1, 1'b1}) begin errors++;
         $display("FAIL clr_load_setup: got %0d%0d ovf=%0b run=%0b expected 27 ovf=1 run=1", d, u, ovf, run); end
      clr = 1; load = 1; ld_u = 4'd3; ld_d = 3'd3; tick(); clr = 0; load = 0;
      checks++; if ({d, u, ovf, run} !== 9'd0) begin errors++;
         $display("FAIL clr_beats_load: got %0d%0d ovf=%0b run=%0b expected 00 ovf=0 run=0", d, u, ovf, run); end
   endtask

   task automatic test_async_reset();
      do_load(4'd9, 3'd5);
      do_start();
      p = 1;
      #2 rst_n = 0;
      #1;
      checks++; if ({u, d, run, cy, ovf} !== 10'd0) begin errors++;
         $display("FAIL async_reset_immediate: got u=%0d d=%0d run=%0b cy=%0b ovf=%0b expected all 0", u, d, run, cy, ovf); end
      tick();
      #2 rst_n = 1;
      tick();
      checks++; if ({u, d, run, cy, ovf} !== 10'd0) begin errors++;
         $display("FAIL async_reset_release: got u=%0d d=%0d run=%0b cy=%0b ovf=%0b expected all 0", u, d, run, cy, ovf); end
      p = 0; tick();
      checks++; if ({u, d, cy} !== 8'd0) begin errors++;
         $display("FAIL async_reset_no_cy: got u=%0d d=%0d cy=%0b expected 0 0 0", u, d, cy); end
   endtask

   initial begin
      test_reset();
      test_count();
      test_wrap();
      test_stop_with_p();
      test_illegal_load();
      test_start_stop_both();
      test_clr_load();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
